// File: rtl/cache_dm_wb_if.sv
// Core-side and memory-side bus bundle for the direct-mapped write-back cache.
// The master modport is the cache itself; the slave modport is the core/memory environment.
interface cache_dm_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_rdata, proc_stall,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_rdata, proc_stall,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 32-bit core words over 128-bit memory lines.
// The core request is not latched; the core holds proc_* stable while proc_stall is high.
module cache_dm_wb #(
  parameter int LINE_NUM = 8,
  parameter int INDEX_W  = 3,
  parameter int TAG_W    = 28 - INDEX_W
) (
  input  logic          clk,
  input  logic          rst,
  cache_dm_wb_if.master bus
);

  localparam logic [1:0] S_COMPARE   = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;

  logic [1:0]          state_r;
  logic [127:0]        data_r [LINE_NUM];
  logic [TAG_W-1:0]    tag_r  [LINE_NUM];
  logic [LINE_NUM-1:0] valid_r;
  logic [LINE_NUM-1:0] dirty_r;

  logic                mem_read_r;
  logic                mem_write_r;
  logic [27:0]         mem_addr_r;
  logic [127:0]        mem_wdata_r;

  logic [INDEX_W-1:0]  idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic [1:0]          off_s;
  logic                hit_s;
  logic                req_s;
  logic                stall_s;

  function automatic logic [31:0] word_get(input logic [127:0] line, input logic [1:0] off);
    return line[{off, 5'd0} +: 32];
  endfunction

  function automatic logic [127:0] word_put(input logic [127:0] line, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [127:0] l;
    l = line;
    l[{off, 5'd0} +: 32] = w;
    return l;
  endfunction

  assign idx_s = bus.proc_addr[INDEX_W+1:2];
  assign tag_s = bus.proc_addr[29:INDEX_W+2];
  assign off_s = bus.proc_addr[1:0];
  assign hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign req_s = bus.proc_read || bus.proc_write;

  assign bus.proc_rdata = word_get(data_r[idx_s], off_s);
  assign bus.proc_stall = stall_s;
  assign bus.mem_read   = mem_read_r;
  assign bus.mem_write  = mem_write_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;

  // Stall decode: only a hit (or no request) in COMPARE lets the core proceed.
  always_comb begin
    stall_s = 1'b1;
    case (state_r)
      S_COMPARE: begin
        if (req_s && !hit_s) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      default: stall_s = 1'b1;
    endcase
  end

  // Miss FSM, line status bits and registered memory-side request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_COMPARE;
      valid_r     <= '0;
      dirty_r     <= '0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= 28'd0;
      mem_wdata_r <= 128'd0;
    end else begin
      case (state_r)
        S_COMPARE: begin
          if (req_s && !hit_s) begin
            if (valid_r[idx_s] && dirty_r[idx_s]) begin
              mem_write_r <= 1'b1;
              mem_addr_r  <= {tag_r[idx_s], idx_s};
              mem_wdata_r <= data_r[idx_s];
              state_r     <= S_WRITEBACK;
            end else begin
              mem_read_r  <= 1'b1;
              mem_addr_r  <= bus.proc_addr[29:2];
              state_r     <= S_ALLOCATE;
            end
          end else if (bus.proc_write && hit_s) begin
            dirty_r[idx_s] <= 1'b1;
          end
        end
        // Writeback completes before the refill is issued, so the two never overlap.
        S_WRITEBACK: begin
          if (bus.mem_ready) begin
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b1;
            mem_addr_r  <= bus.proc_addr[29:2];
            state_r     <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (bus.mem_ready) begin
            mem_read_r     <= 1'b0;
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
            state_r        <= S_COMPARE;
          end
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          state_r     <= S_COMPARE;
        end
      endcase
    end
  end

  // Data and tag arrays: write-hit word merge and line refill; no reset needed.
  always_ff @(posedge clk) begin
    if ((state_r == S_COMPARE) && bus.proc_write && hit_s) begin
      data_r[idx_s] <= word_put(data_r[idx_s], off_s, bus.proc_wdata);
    end else if ((state_r == S_ALLOCATE) && bus.mem_ready) begin
      data_r[idx_s] <= bus.mem_rdata;
      tag_r[idx_s]  <= tag_s;
    end
  end

endmodule

// File: doc/cache_dm_wb.md
Name: cache_dm_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the RISC-V core and the slow 128-bit line memory.
- Acts as the initiator on the memory-side handshake: holds mem_read or mem_write with address and data until mem_ready pulses.
- Serves 32-bit word accesses from the core.
- Stalls the core through proc_stall on every miss.

Parameters:
- LINE_NUM, 8: number of cache lines (power of 2).
- INDEX_W, 3: log2(LINE_NUM).
- TAG_W, 25: 28 - INDEX_W; line-address bits held in each tag.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- proc_read  in  1  core word read request.
- proc_write  in  1  core word write request (never asserted together with proc_read).
- proc_addr  in  30  word address: [1:0] word offset, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  in  32  write word.
- proc_rdata  out  32  read word; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  high while the request cannot complete this cycle.
- mem_read  out  1  line read request (registered).
- mem_write  out  1  line write request (registered).
- mem_addr  out  28  line address {tag,index} (registered).
- mem_wdata  out  128  line write data, word0 in [31:0] (registered).
- mem_rdata  in  128  line read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset, asynchronous:
  - All valid and dirty bits cleared.
  - state = COMPARE.
  - mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - Data and tag arrays need no reset.
  - proc_stall is combinational: 0 in COMPARE with no request, 1 otherwise as defined below.
- hit = valid[idx] && tag[idx] == proc_addr tag field.
- COMPARE state:
  - No request: proc_stall = 0, stay in COMPARE.
  - Read hit: proc_stall = 0; proc_rdata = word[offset] of the line, combinational, same cycle.
  - Write hit: proc_stall = 0; at posedge, word[offset] <= proc_wdata and dirty[idx] <= 1.
  - Miss with the line clean or invalid: proc_stall = 1; at posedge set mem_read = 1, mem_addr = proc_addr[29:2], go to ALLOCATE.
  - Miss with the line valid and dirty: proc_stall = 1; at posedge set mem_write = 1, mem_addr = {tag[idx], idx}, mem_wdata = line[idx], go to WRITEBACK.
- WRITEBACK state:
  - proc_stall = 1; mem_* outputs held stable.
  - On a posedge with mem_ready = 1: mem_write <= 0, mem_read <= 1, mem_addr <= proc_addr[29:2], go to ALLOCATE. Writeback and refill never overlap.
- ALLOCATE state:
  - proc_stall = 1; outputs held stable.
  - On a posedge with mem_ready = 1: mem_read <= 0; line[idx] <= mem_rdata, tag[idx] <= new tag, valid <= 1, dirty <= 0; go to COMPARE.
  - The next cycle is then a hit; a write sets dirty at that point.
- Request drop rule: request outputs fall at the same posedge that samples mem_ready = 1. A request is never held past the ready pulse, so memory does not re-trigger.
- mem_ready seen in COMPARE is ignored.
- Latency: a hit has 0 stall cycles. A clean miss stalls for memory latency + 1 cycles. A dirty miss stalls for 2 x memory latency + 1 cycles.
- The core holds proc_* stable while proc_stall = 1; the cache does not latch the core request.
- Reset asserted mid-miss: the FSM returns to COMPARE immediately and requests drop asynchronously. Any later mem_ready pulse is ignored.
- proc_read and proc_write both high is illegal; the behaviour is undefined and is not checked.

Test Plan:
- Reset, then read 0x00000010 with memory line 0x0000004 = {0x4444_4444, 0x3333_3333, 0x2222_2222, 0x1111_1111} -> mem_read pulse with mem_addr = 0x0000004; stall until ready + 1; proc_rdata = 0x1111_1111; no mem_write.
- Read 0x00000011 immediately after that miss -> proc_stall = 0 in the same cycle; proc_rdata = 0x2222_2222; no memory traffic.
- Write 0xDEADBEEF to 0x00000012 (hit), then read 0x00000012 (hit) -> 0xDEADBEEF, zero stall cycles; memory unchanged.
- Read 0x00000112 (same index 4, different tag) after the dirty write -> first mem_write with mem_addr = 0x0000004 and mem_wdata[95:64] = 0xDEADBEEF, then mem_read with mem_addr = 0x0000044; never both high; each drops at its ready pulse.
- Assert rst during ALLOCATE -> mem_read = 0 and proc_stall = 0 (no request) immediately. A re-read of the same address misses again (valid cleared).
- 200 random read/write sequences against a reference model with 15-cycle memory latency -> every proc_rdata matches the model; after a final flush-by-eviction, memory contents match the model.
